bundle_tx: RTL and testbench
============================

# bundle_tx

Byte-stream to ctrl/data bundle packer. Accepts one byte per cycle on a valid/ready input and packs bytes little-endian into BITS-wide words. Emits each word on the `t__ctrl`/`t__data` bundle with a valid/ready handshake. It is the transmitting end of the ctrl/data bundle interface that downstream bundle consumers receive.

## Interface
- `BITS`, default 32: bundle data width; legal values 8, 16, 32. `BYTES = BITS/8`.
- `CNT_BITS`, default 16: width of the packet counter.

Ports:
- `clk`  input  1: clock.
- `rst`  input  1: asynchronous, active-high reset.
- `s__valid`  input  1: input byte valid.
- `s__ready`  output  1: input byte accepted when `s__valid & s__ready` at the rising edge.
- `s__byte`  input  8: input byte.
- `s__last`  input  1: byte is the final byte of a packet.
- `t__valid`  output  1: bundle word valid.
- `t__ready`  input  1: downstream accepts the word when `t__valid & t__ready`.
- `t__ctrl`  output  8: `[3:0]` byte enable, `[4]` last, `[7:5]` word sequence number.
- `t__data`  output  BITS: packed data, first byte in `[7:0]`.
- `pkt_count`  output  CNT_BITS: number of last-flagged words accepted downstream.

## Operation
- Accumulator holds up to BYTES bytes, a fill index `idx` (0..BYTES-1) and a byte-enable mask.
- An accepted byte is written to lane `idx`, sets mask bit `idx`, and `idx` increments.
- A word completes when the byte lands in lane BYTES-1, or when `s__last` is set on the accepted byte.
- On completion the word loads into the output register:
  - Filled lanes carry data; unfilled lanes are 0.
  - `ctrl.be` = mask; bits above BYTES-1 are always 0.
  - `ctrl.last` = `s__last`; `ctrl.seq` = current `seq`.
  - The accumulator clears (`idx` = 0, mask = 0).
- `seq` (3-bit) increments per loaded word and wraps 7 -> 0. It resets to 0 after a word with last=1 is loaded.
- Output register states are EMPTY and FULL:
  - EMPTY -> FULL on load.
  - FULL -> EMPTY on `t__valid & t__ready` with no load that cycle.
  - FULL stays FULL on a drain and a load in the same cycle.
- `s__ready = !t__valid | t__ready`. This is combinational from `t__ready`, and applies equally to completing and non-completing bytes.
- `pkt_count` increments on each accepted word with `ctrl.last` = 1 and wraps at 2^CNT_BITS.
- Output data and ctrl are held stable while `t__valid & !t__ready`.

## Timing
- Reset values:
  - `t__valid` = 0, `t__ctrl` = 0, `t__data` = 0, `pkt_count` = 0.
  - `seq` = 0, `idx` = 0, mask = 0.
  - `s__ready` = 1 once reset deasserts.
- Reset mid-packet discards the partial accumulator and any pending output word. No partial word is emitted.
- Latency: the completing byte is accepted at edge N, and `t__valid` = 1 in the cycle after edge N.
- Throughput with `t__ready` held at 1: one byte per cycle and one word per BYTES cycles, with no bubbles.
- A single-byte packet (`s__last` on the first byte) produces one word with be = 0001 and last = 1.
- With BITS = 8, every byte is a complete word and be is always 0001.
- Upstream must hold `s__byte`/`s__last` stable while `s__valid & !s__ready`.

## Structure
- Package `bundle_pkg`:
  - `BUNDLE_CTRL_W` = 8.
  - Field position constants BE_LSB=0, LAST_BIT=4, SEQ_LSB=5.
  - `typedef struct packed {logic [2:0] seq; logic last; logic [3:0] be;} bundle_ctrl_t`.
- One sub-module, `bundle_tx_acc`: accumulator with lane write, `idx`, mask, and a completion flag.
- The top level holds the output register, handshake, `seq` and `pkt_count`.

## Test plan
- Reset release, then 8 bytes 0x01..0x08 with last on 0x08, `t__ready`=1:
  - Word 0: data 0x04030201, ctrl 0x0F.
  - Word 1: data 0x08070605, ctrl 0x3F (seq 1, last 1, be F).
  - `pkt_count` = 1.
- 6-byte packet 0xA0..0xA5:
  - Second word data 0x0000A5A4, ctrl 0x33.
  - The next packet starts at seq 0.
- `t__ready` = 0 for 10 cycles with the output FULL:
  - `s__ready` = 0.
  - `t__data`/`t__ctrl` stable.
  - No byte lost when `t__ready` returns to 1.
- 36-byte packet (9 words): seq runs 0..7, then 0 on the last word; that word's ctrl = 0x1F.
- Assert `rst` after 2 bytes of a packet:
  - All outputs return to 0.
  - The next packet's first word contains only new bytes, seq 0.
- `pkt_count` with CNT_BITS=2 after 5 single-byte packets reads 1 (wrap).

Source files
------------

// File: rtl/bundle_pkg.sv
// bundle_pkg: shared types and constants for the ctrl/data bundle interface.
//   bundle_ctrl_t : 8-bit control word {seq[2:0], last, be[3:0]}
//   out_state_e   : output register occupancy (EMPTY/FULL)
package bundle_pkg;

   localparam int BUNDLE_CTRL_W = 8;
   localparam int BE_LSB        = 0;
   localparam int LAST_BIT      = 4;
   localparam int SEQ_LSB       = 5;

   typedef struct packed {
      logic [2:0] seq;
      logic       last;
      logic [3:0] be;
   } bundle_ctrl_t;

   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } out_state_e;

endpackage

// File: rtl/bundle_tx_acc.sv
// bundle_tx_acc: byte accumulator for bundle_tx.
//   clk, rst    : clock, async active-high reset
//   fire        : a byte is accepted this cycle
//   byte_in     : accepted byte
//   last_in     : accepted byte ends a packet
//   complete    : this accepted byte finishes a word
//   word_data   : word including the current byte (unfilled lanes 0)
//   word_mask   : lane mask including the current byte
module bundle_tx_acc
   import bundle_pkg::*;
#(
   parameter int BYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  fire,
   input  logic [7:0]            byte_in,
   input  logic                  last_in,
   output logic                  complete,
   output logic [BYTES*8-1:0]    word_data,
   output logic [BYTES-1:0]      word_mask
);

   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;

   logic [BYTES-1:0][7:0] data_q, data_d, lanes;
   logic [BYTES-1:0]      mask_q, mask_d;
   logic [IDX_W-1:0]      idx_q, idx_d;

   // Lanes are cleared on every completion, so unfilled lanes of an
   // outgoing word are already zero without extra masking.
   always_comb begin
      lanes          = data_q;
      lanes[idx_q]   = byte_in;
      word_data      = lanes;
      word_mask      = mask_q;
      word_mask[idx_q] = 1'b1;
      complete       = fire & ((idx_q == IDX_W'(BYTES-1)) | last_in);

      data_d = data_q;
      mask_d = mask_q;
      idx_d  = idx_q;
      if (complete) begin
         data_d = '0;
         mask_d = '0;
         idx_d  = '0;
      end else if (fire) begin
         data_d = lanes;
         mask_d = word_mask;
         idx_d  = idx_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data_q <= '0;
         mask_q <= '0;
         idx_q  <= '0;
      end else begin
         data_q <= data_d;
         mask_q <= mask_d;
         idx_q  <= idx_d;
      end
   end

endmodule

// File: rtl/bundle_tx.sv
// bundle_tx: packs a valid/ready byte stream little-endian into BITS-wide
// words and emits them on the t__ctrl/t__data bundle.
//   s__valid/s__ready/s__byte/s__last : byte input stream
//   t__valid/t__ready/t__ctrl/t__data : bundle output
//   pkt_count : count of last-flagged words accepted downstream (wraps)
module bundle_tx
   import bundle_pkg::*;
#(
   parameter int BITS     = 32,
   parameter int CNT_BITS = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                s__valid,
   output logic                s__ready,
   input  logic [7:0]          s__byte,
   input  logic                s__last,
   output logic                t__valid,
   input  logic                t__ready,
   output logic [7:0]          t__ctrl,
   output logic [BITS-1:0]     t__data,
   output logic [CNT_BITS-1:0] pkt_count
);

   localparam int BYTES = BITS / 8;

   out_state_e            state_q, state_d;
   bundle_ctrl_t          ctrl_q, ctrl_d;
   logic [BITS-1:0]       data_q, data_d;
   logic [2:0]            seq_q, seq_d;
   logic [CNT_BITS-1:0]   pkt_q, pkt_d;

   logic                  fire, drain, complete;
   logic [BITS-1:0]       acc_data;
   logic [BYTES-1:0]      acc_mask;

   bundle_tx_acc #(.BYTES(BYTES)) u_acc (
      .clk       (clk),
      .rst       (rst),
      .fire      (fire),
      .byte_in   (s__byte),
      .last_in   (s__last),
      .complete  (complete),
      .word_data (acc_data),
      .word_mask (acc_mask)
   );

   // Ready gates every byte, not just completing ones, so a stalled output
   // register freezes the accumulator as well.
   always_comb begin
      s__ready = (state_q == EMPTY) | t__ready;
      fire     = s__valid & s__ready;
      drain    = (state_q == FULL) & t__ready;
   end

   always_comb begin
      state_d = state_q;
      ctrl_d  = ctrl_q;
      data_d  = data_q;
      seq_d   = seq_q;
      pkt_d   = pkt_q;

      case (state_q)
         EMPTY:   if (complete) state_d = FULL;
         FULL:    if (drain && !complete) state_d = EMPTY;
         default: state_d = EMPTY;
      endcase

      if (complete) begin
         data_d                = acc_data;
         ctrl_d.be             = '0;
         ctrl_d.be[BYTES-1:0]  = acc_mask;
         ctrl_d.last           = s__last;
         ctrl_d.seq            = seq_q;
         seq_d                 = s__last ? 3'd0 : seq_q + 3'd1;
      end

      if (drain && ctrl_q.last) pkt_d = pkt_q + 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= EMPTY;
         ctrl_q  <= '0;
         data_q  <= '0;
         seq_q   <= '0;
         pkt_q   <= '0;
      end else begin
         state_q <= state_d;
         ctrl_q  <= ctrl_d;
         data_q  <= data_d;
         seq_q   <= seq_d;
         pkt_q   <= pkt_d;
      end
   end

   assign t__valid  = (state_q == FULL);
   assign t__ctrl   = ctrl_q;
   assign t__data   = data_q;
   assign pkt_count = pkt_q;

endmodule

// File: tb/tb_bundle_tx.sv
// tb_bundle_tx: directed table plus randomized traffic against a
// queue-based packing model for bundle_tx (BITS=32), and a small
// BITS=8 / CNT_BITS=2 instance for single-byte words and counter wrap.
module tb_bundle_tx;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        s_valid = 1'b0, s_last = 1'b0, t_ready = 1'b1;
   logic [7:0]  s_byte = 8'h00;
   logic        s_ready, t_valid;
   logic [7:0]  t_ctrl;
   logic [31:0] t_data;
   logic [15:0] pkt_count;

   logic        s_valid2 = 1'b0, s_last2 = 1'b0, t_ready2 = 1'b1;
   logic [7:0]  s_byte2 = 8'h00;
   logic        s_ready2, t_valid2;
   logic [7:0]  t_ctrl2, t_data2;
   logic [1:0]  pkt_count2;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   bundle_tx #(.BITS(32), .CNT_BITS(16)) dut (
      .clk(clk), .rst(rst),
      .s__valid(s_valid), .s__ready(s_ready), .s__byte(s_byte), .s__last(s_last),
      .t__valid(t_valid), .t__ready(t_ready), .t__ctrl(t_ctrl), .t__data(t_data),
      .pkt_count(pkt_count)
   );

   bundle_tx #(.BITS(8), .CNT_BITS(2)) dut2 (
      .clk(clk), .rst(rst),
      .s__valid(s_valid2), .s__ready(s_ready2), .s__byte(s_byte2), .s__last(s_last2),
      .t__valid(t_valid2), .t__ready(t_ready2), .t__ctrl(t_ctrl2), .t__data(t_data2),
      .pkt_count(pkt_count2)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // ---------------- reference model: bytes -> expected words ----------------
   logic [7:0]  part_q[$];
   logic [39:0] exp_q[$];   // {ctrl, data}
   int          m_seq = 0;
   int          m_pkt = 0;

   always @(negedge clk) begin
      if (rst) begin
         part_q.delete();
         exp_q.delete();
         m_seq = 0;
         m_pkt = 0;
      end else begin
         // Drain first: the word in the register is always older than a new load.
         if (t_valid && t_ready) begin
            if (exp_q.size() == 0) begin
               check("sb_unexpected_word", {t_ctrl, 24'h0}, 32'hFFFFFFFF);
            end else begin
               logic [39:0] e;
               e = exp_q.pop_front();
               check("sb_data", t_data, e[31:0]);
               check("sb_ctrl", {24'h0, t_ctrl}, {24'h0, e[39:32]});
               if (e[36]) m_pkt = (m_pkt + 1) % 65536;
            end
         end
         if (s_valid && s_ready) begin
            part_q.push_back(s_byte);
            if (part_q.size() == 4 || s_last) begin
               logic [31:0] d;
               logic [3:0]  be;
               d  = '0;
               be = '0;
               for (int i = 0; i < part_q.size(); i++) begin
                  d[8*i +: 8] = part_q[i];
                  be[i]       = 1'b1;
               end
               exp_q.push_back({3'(m_seq), s_last, be, d});
               m_seq = s_last ? 0 : (m_seq + 1) % 8;
               part_q.delete();
            end
         end
      end
   end

   // ---------------- directed table ----------------
   typedef struct {
      logic [7:0]  b;
      bit          last;
      bit          chk;
      logic [31:0] d;
      logic [7:0]  c;
   } vec_t;

   vec_t tbl[14];

   initial begin
      logic [31:0] held_d;
      logic [7:0]  held_c;
      bit          hold;

      for (int i = 0; i < 8; i++) tbl[i] = '{8'(i + 1), i == 7, 0, 32'h0, 8'h0};
      tbl[3].chk = 1; tbl[3].d = 32'h04030201; tbl[3].c = 8'h0F;
      tbl[7].chk = 1; tbl[7].d = 32'h08070605; tbl[7].c = 8'h3F;
      for (int i = 0; i < 6; i++) tbl[8 + i] = '{8'hA0 + 8'(i), i == 5, 0, 32'h0, 8'h0};
      tbl[11].chk = 1; tbl[11].d = 32'hA3A2A1A0; tbl[11].c = 8'h0F;
      tbl[13].chk = 1; tbl[13].d = 32'h0000A5A4; tbl[13].c = 8'h33;

      // Reset state
      #2;
      check("rst_t_valid", {31'h0, t_valid}, 32'h0);
      check("rst_t_ctrl",  {24'h0, t_ctrl}, 32'h0);
      check("rst_t_data",  t_data, 32'h0);
      check("rst_pkt",     {16'h0, pkt_count}, 32'h0);
      step(); step();
      rst = 1'b0;
      #1;
      check("s_ready_after_rst", {31'h0, s_ready}, 32'h1);

      // Table: bytes streamed with t_ready=1, word checked one cycle after completion
      t_ready = 1'b1;
      for (int i = 0; i < 14; i++) begin
         s_valid = 1'b1; s_byte = tbl[i].b; s_last = tbl[i].last;
         step();
         if (tbl[i].chk) begin
            check($sformatf("tbl%0d_valid", i), {31'h0, t_valid}, 32'h1);
            check($sformatf("tbl%0d_data", i), t_data, tbl[i].d);
            check($sformatf("tbl%0d_ctrl", i), {24'h0, t_ctrl}, {24'h0, tbl[i].c});
         end
      end
      s_valid = 1'b0; s_last = 1'b0;
      step();
      check("pkt_after_tbl", {16'h0, pkt_count}, 32'd2);
      check("t_valid_idle", {31'h0, t_valid}, 32'h0);

      // Stall: output FULL with t_ready=0 for 10 cycles
      t_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_byte = 8'h11 + 8'(i); s_last = 1'b0;
         step();
      end
      s_byte = 8'h15;
      held_d = t_data; held_c = t_ctrl;
      check("stall_word", held_d, 32'h14131211);
      for (int i = 0; i < 10; i++) begin
         check("stall_s_ready", {31'h0, s_ready}, 32'h0);
         check("stall_data", t_data, held_d);
         check("stall_ctrl", {24'h0, t_ctrl}, {24'h0, held_c});
         step();
      end
      t_ready = 1'b1;
      step();  // 0x15 accepted here
      for (int i = 0; i < 3; i++) begin
         s_byte = 8'h16 + 8'(i); s_last = (i == 2);
         step();
      end
      check("stall_tail", t_data, 32'h18171615);
      s_valid = 1'b0; s_last = 1'b0;
      step();

      // 36-byte packet: 9 words, seq 0..7 then 0
      for (int i = 0; i < 36; i++) begin
         s_valid = 1'b1; s_byte = 8'(i); s_last = (i == 35);
         step();
         if (i % 4 == 3) check($sformatf("long_seq%0d", i / 4), {29'h0, t_ctrl[7:5]}, (i / 4) % 8);
      end
      check("long_last_ctrl", {24'h0, t_ctrl}, 32'h1F);
      s_valid = 1'b0; s_last = 1'b0;
      step();

      // Reset mid-packet
      s_valid = 1'b1; s_byte = 8'hE1; step();
      s_byte = 8'hE2; step();
      s_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("midrst_valid", {31'h0, t_valid}, 32'h0);
      check("midrst_ctrl",  {24'h0, t_ctrl}, 32'h0);
      check("midrst_data",  t_data, 32'h0);
      check("midrst_pkt",   {16'h0, pkt_count}, 32'h0);
      step();
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         s_valid = 1'b1; s_byte = 8'hC0 + 8'(i); s_last = 1'b0;
         step();
      end
      check("postrst_data", t_data, 32'hC3C2C1C0);
      check("postrst_ctrl", {24'h0, t_ctrl}, 32'h0F);
      s_byte = 8'hC4; s_last = 1'b1; step();
      check("postrst_tail_ctrl", {24'h0, t_ctrl}, 32'h31);
      s_valid = 1'b0; s_last = 1'b0;
      step();

      // BITS=8, CNT_BITS=2: five single-byte packets, counter wraps to 1
      for (int i = 0; i < 5; i++) begin
         s_valid2 = 1'b1; s_byte2 = 8'h50 + 8'(i); s_last2 = 1'b1;
         step();
         check("b8_data", {24'h0, t_data2}, {24'h0, 8'h50 + 8'(i)});
         check("b8_ctrl", {24'h0, t_ctrl2}, 32'h11);
      end
      s_valid2 = 1'b0; s_last2 = 1'b0;
      step();
      check("b8_pkt_wrap", {30'h0, pkt_count2}, 32'd1);

      // Randomized traffic; upstream holds byte/last while stalled
      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(negedge clk);
         hold = s_valid && !s_ready;
         @(posedge clk);
         #1;
         t_ready = ($urandom_range(3) != 0);
         if (!hold) begin
            s_valid = ($urandom_range(4) != 0);
            s_byte  = 8'($urandom);
            s_last  = ($urandom_range(5) == 0);
         end
      end
      // finish any in-flight byte, then close the packet and drain
      begin
         int budget = 0;
         t_ready = 1'b1;
         if (s_valid) begin s_last = 1'b1; step(); end
         s_valid = 1'b1; s_byte = 8'h77; s_last = 1'b1;
         step();
         s_valid = 1'b0; s_last = 1'b0;
         while (exp_q.size() != 0 && budget < 20) begin step(); budget++; end
         step();
         check("rand_drained", exp_q.size(), 32'h0);
         check("rand_pkt", {16'h0, pkt_count}, m_pkt);
         check("rand_idle_valid", {31'h0, t_valid}, 32'h0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
